// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM stage and dmem: stores are queued in
// program order and drained into the shared dmem port whenever no load holds it.

module store_buffer_entry (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        clr,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [1:0]  wr_size,
    input  logic [29:0] ld_word,
    output logic [31:0] addr,
    output logic [31:0] data,
    output logic [1:0]  size,
    output logic        match
);
    logic valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     valid <= 1'b0;
        else if (wr_en) valid <= 1'b1;
        else if (clr)   valid <= 1'b0;
    end

    // Payload needs no reset: it is only observed while valid is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            addr <= wr_addr;
            data <= wr_data;
            size <= wr_size;
        end
    end

    // Word-granular compare: any byte overlap in the same word counts as a hit.
    assign match = valid & (addr[31:2] == ld_word);
endmodule

module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            st_valid,
    input  logic [31:0]     st_addr,
    input  logic [31:0]     st_data,
    input  logic [1:0]      st_size,
    output logic            st_ready,
    input  logic            ld_valid,
    input  logic [31:0]     ld_addr,
    input  logic [1:0]      ld_size,
    output logic            ld_hazard,
    input  logic            flush_req,
    output logic            flush_done,
    output logic [31:0]     dm_addr,
    output logic [31:0]     dm_wData,
    output logic [1:0]      dm_dsize,
    output logic            dm_writeEnable,
    output logic            empty,
    output logic [CNTW-1:0] count,
    output logic            err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    state_t                  state, state_nxt;
    logic [AW-1:0]           head, tail;
    logic [CNTW-1:0]         count_nxt;
    logic [DEPTH-1:0][31:0]  e_addr, e_data;
    logic [DEPTH-1:0][1:0]   e_size;
    logic [DEPTH-1:0]        e_match;
    logic                    accept, bad, push, pop, hit, grant;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_ent
            store_buffer_entry u_ent (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_en   (push & (tail == AW'(i))),
                .clr     (pop  & (head == AW'(i))),
                .wr_addr (st_addr),
                .wr_data (st_data),
                .wr_size (st_size),
                .ld_word (ld_addr[31:2]),
                .addr    (e_addr[i]),
                .data    (e_data[i]),
                .size    (e_size[i]),
                .match   (e_match[i])
            );
        end
    endgenerate

    // A rejected store is still consumed so the pipeline never retries it.
    always_comb begin
        accept = st_valid & st_ready;
        bad    = (st_size == 2'd2)
               | ((st_size == 2'd3) & (|st_addr[1:0]))
               | ((st_size == 2'd1) & st_addr[0]);
        push   = accept & ~bad;
    end

    assign empty     = (count == '0);
    assign hit       = ld_valid & (|e_match);
    assign ld_hazard = hit;
    assign grant     = ~empty & (~ld_valid | hit);
    assign pop       = grant;
    assign count_nxt = count + CNTW'(push) - CNTW'(pop);

    always_comb begin
        dm_addr        = ld_addr;
        dm_wData       = '0;
        dm_dsize       = ld_size;
        dm_writeEnable = 1'b0;
        if (grant) begin
            dm_addr        = e_addr[head];
            dm_wData       = e_data[head];
            dm_dsize       = e_size[head];
            dm_writeEnable = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (flush_req) state_nxt = FLUSH;
            FLUSH:   if (count_nxt == '0) state_nxt = DONE;
            DONE:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // st_ready and flush_done are registered off the next-state view.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            st_ready   <= 1'b1;
            flush_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            st_ready   <= (count_nxt < CNTW'(DEPTH)) & (state_nxt == RUN);
            flush_done <= (state_nxt == DONE);
            if (push)         tail <= tail + AW'(1);
            if (pop)          head <= head + AW'(1);
            if (accept & bad) err  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboarded bench for store_buffer with a little-endian byte-addressed dmem model.

module tb_store_buffer;
    logic        clk = 0, rst_n = 0;
    logic        st_valid = 0, ld_valid = 0, flush_req = 0;
    logic [31:0] st_addr = 0, st_data = 0, ld_addr = 0;
    logic [1:0]  st_size = 0, ld_size = 0;
    logic        st_ready, ld_hazard, flush_done, dm_writeEnable, empty, err;
    logic [31:0] dm_addr, dm_wData;
    logic [1:0]  dm_dsize;
    logic [2:0]  count;

    typedef struct packed {logic [31:0] a; logic [31:0] d; logic [1:0] s;} wr_t;
    wr_t exp_q[$];
    logic [7:0] mem [0:4095];
    int n_chk = 0, n_fail = 0;

    store_buffer #(.DEPTH(4), .CNTW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size), .ld_hazard(ld_hazard),
        .flush_req(flush_req), .flush_done(flush_done),
        .dm_addr(dm_addr), .dm_wData(dm_wData), .dm_dsize(dm_dsize),
        .dm_writeEnable(dm_writeEnable),
        .empty(empty), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // dmem model: commits at the rising edge, byte lanes little-endian
    always @(posedge clk) begin
        if (rst_n && dm_writeEnable) begin
            mem[dm_addr[11:0]] <= dm_wData[7:0];
            if (dm_dsize != 2'd0) mem[dm_addr[11:0] + 12'd1] <= dm_wData[15:8];
            if (dm_dsize == 2'd3) begin
                mem[dm_addr[11:0] + 12'd2] <= dm_wData[23:16];
                mem[dm_addr[11:0] + 12'd3] <= dm_wData[31:24];
            end
        end
    end

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {mem[a[11:0] + 12'd3], mem[a[11:0] + 12'd2], mem[a[11:0] + 12'd1], mem[a[11:0]]};
    endfunction

    // Monitor: every dmem write must match the oldest expected store
    always @(negedge clk) begin
        if (rst_n && dm_writeEnable) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", dm_addr, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", dm_addr, e.a);
                chk("wr_data", dm_wData, e.d);
                chk("wr_size", {30'd0, dm_dsize}, {30'd0, e.s});
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         input bit good);
        st_valid = 1; st_addr = a; st_data = d; st_size = s;
        chk("st_ready_pre", {31'd0, st_ready}, 32'd1);
        tick();
        st_valid = 0;
        if (good) exp_q.push_back('{a, d, s});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, writes;
        for (int k = 0; k < 4096; k++) mem[k] = 8'h00;

        // reset values
        neg();
        chk("rst_st_ready", {31'd0, st_ready}, 32'd1);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
        chk("rst_we", {31'd0, dm_writeEnable}, 32'd0);
        chk("rst_hazard", {31'd0, ld_hazard}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        tick(); rst_n = 1; tick();

        // single word store drains the next cycle, then load reads it back
        store(32'h100, 32'hDEAD_BEEF, 2'd3, 1);
        neg();
        chk("t2_count1", {29'd0, count}, 32'd1);
        chk("t2_we", {31'd0, dm_writeEnable}, 32'd1);
        tick();
        neg();
        chk("t2_count0", {29'd0, count}, 32'd0);
        tick();
        ld_valid = 1; ld_addr = 32'h100; ld_size = 2'd3;
        neg();
        chk("t2_ld_we", {31'd0, dm_writeEnable}, 32'd0);
        chk("t2_ld_addr", dm_addr, 32'h100);
        chk("t2_ld_data", rd_word(dm_addr), 32'hDEAD_BEEF);
        tick();

        // fill while unrelated loads hold the port
        ld_addr = 32'h400;
        for (int k = 0; k < 4; k++) begin
            store(32'h10 + 32'(4 * k), 32'hA0 + 32'(k), 2'd3, 1);
            neg();
            chk("t3_no_write", {31'd0, dm_writeEnable}, 32'd0);
            if (k == 3) begin
                chk("t3_full_ready", {31'd0, st_ready}, 32'd0);
                chk("t3_full_count", {29'd0, count}, 32'd4);
            end
            tick();
        end
        ld_valid = 0;
        for (int k = 0; k < 4; k++) begin
            neg();
            chk("t3_drain_we", {31'd0, dm_writeEnable}, 32'd1);
            chk("t3_drain_count", {29'd0, count}, 32'(4 - k));
            tick();
        end
        neg();
        chk("t3_empty", {31'd0, empty}, 32'd1);
        tick();

        // load overlapping a pending byte store stalls until drained
        ld_valid = 1; ld_addr = 32'h400;
        store(32'h300, 32'h1234_5678, 2'd3, 1);
        store(32'h203, 32'h7F, 2'd0, 1);
        ld_addr = 32'h200;
        neg();
        chk("t4_hazard0", {31'd0, ld_hazard}, 32'd1);
        chk("t4_we0", {31'd0, dm_writeEnable}, 32'd1);
        tick();
        neg();
        chk("t4_hazard1", {31'd0, ld_hazard}, 32'd1);
        chk("t4_count1", {29'd0, count}, 32'd1);
        tick();
        neg();
        chk("t4_hazard_clr", {31'd0, ld_hazard}, 32'd0);
        chk("t4_ld_we", {31'd0, dm_writeEnable}, 32'd0);
        chk("t4_ld_data", rd_word(dm_addr), 32'h7F00_0000);
        tick();
        ld_valid = 0;

        // illegal stores are consumed, not enqueued, and set sticky err
        store(32'h102, 32'h55, 2'd3, 0);
        neg();
        chk("t5_count_a", {29'd0, count}, 32'd0);
        chk("t5_err_a", {31'd0, err}, 32'd1);
        tick();
        store(32'h300, 32'h66, 2'd2, 0);
        neg();
        chk("t5_count_b", {29'd0, count}, 32'd0);
        tick();
        store(32'h101, 32'h77, 2'd1, 0);
        neg();
        chk("t5_count_c", {29'd0, count}, 32'd0);
        tick();
        store(32'h104, 32'hBEEF, 2'd1, 1);
        neg();
        chk("t5_err_sticky", {31'd0, err}, 32'd1);
        tick(); tick();

        // flush with two pending
        ld_valid = 1; ld_addr = 32'h400;
        store(32'h20, 32'h1111_0000, 2'd3, 1);
        store(32'h24, 32'h2222_0000, 2'd3, 1);
        flush_req = 1;
        tick();
        flush_req = 0; ld_valid = 0;
        pulses = 0; writes = 0;
        for (int k = 0; k < 6; k++) begin
            neg();
            if (k == 0) chk("t6_ready_flush", {31'd0, st_ready}, 32'd0);
            if (flush_done) pulses++;
            if (dm_writeEnable) writes++;
            tick();
        end
        chk("t6_pulses", 32'(pulses), 32'd1);
        chk("t6_writes", 32'(writes), 32'd2);
        neg();
        chk("t6_ready_run", {31'd0, st_ready}, 32'd1);
        chk("t6_count", {29'd0, count}, 32'd0);
        tick();

        // flush while empty
        flush_req = 1;
        tick();
        flush_req = 0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            neg();
            if (flush_done) pulses++;
            tick();
        end
        chk("t6_empty_pulses", 32'(pulses), 32'd1);

        // push and pop in the same cycle at DEPTH-1
        ld_valid = 1; ld_addr = 32'h400;
        store(32'h30, 32'h30, 2'd3, 1);
        store(32'h34, 32'h34, 2'd3, 1);
        store(32'h38, 32'h38, 2'd3, 1);
        ld_valid = 0;
        store(32'h3C, 32'h3C, 2'd3, 1);
        neg();
        chk("t7_count_same", {29'd0, count}, 32'd3);
        chk("t7_ready", {31'd0, st_ready}, 32'd1);
        tick(); tick(); tick();
        neg();
        chk("t7_count_end", {29'd0, count}, 32'd0);
        tick();

        // reset with three pending drops them
        ld_valid = 1; ld_addr = 32'h400;
        store(32'h40, 32'h40, 2'd3, 1);
        store(32'h44, 32'h44, 2'd3, 1);
        store(32'h48, 32'h48, 2'd3, 1);
        exp_q.delete();
        rst_n = 0; ld_valid = 0;
        neg();
        chk("t8_count", {29'd0, count}, 32'd0);
        chk("t8_we", {31'd0, dm_writeEnable}, 32'd0);
        chk("t8_err", {31'd0, err}, 32'd0);
        tick();
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            neg();
            chk("t8_no_write", {31'd0, dm_writeEnable}, 32'd0);
            tick();
        end

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
